// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM ownership controllers: owner encoding, FSM states
// and the drain-counter sizing derived from the largest supported read latency.
package sram_ctrl_pkg;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        OWN_HOST = 2'd0,
        OWN_CORE = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    localparam int RD_LAT_MAX = 4;
    localparam int DCNT_W     = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Bus bundle for one SRAM macro: host request port, core request port and the
// macro pins. The master side is the requesters plus the macro model.
interface sram_access_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic [DW-1:0] host_d;
    logic [AW-1:0] host_addr;
    logic          host_cen;
    logic          host_wen;
    logic [DW-1:0] host_q;
    logic          host_q_valid;

    logic [DW-1:0] core_d;
    logic [AW-1:0] core_addr;
    logic          core_cen;
    logic          core_wen;
    logic [DW-1:0] core_q;
    logic          core_q_valid;

    logic [DW-1:0] sram_d;
    logic [AW-1:0] sram_addr;
    logic          sram_cen;
    logic          sram_wen;
    logic [DW-1:0] sram_q;

    modport master (
        output host_d, host_addr, host_cen, host_wen,
        input  host_q, host_q_valid,
        output core_d, core_addr, core_cen, core_wen,
        input  core_q, core_q_valid,
        input  sram_d, sram_addr, sram_cen, sram_wen,
        output sram_q
    );

    modport slave (
        input  host_d, host_addr, host_cen, host_wen,
        output host_q, host_q_valid,
        input  core_d, core_addr, core_cen, core_wen,
        output core_q, core_q_valid,
        output sram_d, sram_addr, sram_cen, sram_wen,
        input  sram_q
    );
endinterface

// File: rtl/sram_access_ctrl_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, owner} alongside the macro's read
// latency so returning data can be steered to the port that issued the read.
module rd_tag_pipe
    import sram_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_vld,
    input  owner_e push_tag,
    output logic   pop_vld,
    output owner_e pop_tag
);
    logic [RD_LAT-1:0] vld_p;
    owner_e            tag_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Tags need no reset: they are only observed when the matching valid is set.
    always_ff @(posedge clk) begin
        tag_p[0] <= push_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

    assign pop_vld = vld_p[RD_LAT-1];
    assign pop_tag = tag_p[RD_LAT-1];
endmodule

// File: rtl/sram_access_ctrl.sv
// Ownership controller for one single-port SRAM shared by host and core; an
// ownership change drains in-flight reads so data returns to its requester.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 7,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_sel,
    output logic              owner,
    output logic              busy,
    output logic              switch_done,
    output logic [CW-1:0]     drop_cnt,
    sram_access_ctrl_if.slave bus
);
    state_e            state, state_nxt;
    logic [DCNT_W-1:0] dcnt;
    owner_e            owner_q;
    logic              switch_done_q;
    logic [CW-1:0]     drop_q;
    logic [AW-1:0]     hold_addr;
    logic [DW-1:0]     hold_d;

    logic              own_host, own_cen, own_wen, oth_req;
    logic              sram_cen, sram_wen;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_d;
    logic [1:0]        drop_n;
    logic              push_vld, pop_vld;
    owner_e            pop_tag;
    logic              host_vld, core_vld;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW+1)'(b);
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= OWN_HOST;
            dcnt          <= '0;
            owner_q       <= HOST;
            switch_done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != DRAIN && state_nxt == DRAIN) begin
                dcnt <= DCNT_W'(RD_LAT);
            end else if (state == DRAIN) begin
                dcnt <= dcnt - DCNT_W'(1);
            end
            if (state_nxt == OWN_HOST) begin
                owner_q <= HOST;
            end else if (state_nxt == OWN_CORE) begin
                owner_q <= CORE;
            end
            // A drain that ends back on the old owner is not a switch.
            switch_done_q <= (state == DRAIN) && (state_nxt != DRAIN)
                             && (owner_e'(host_sel) != owner_q);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            OWN_HOST: if (!host_sel) state_nxt = DRAIN;
            OWN_CORE: if (host_sel) state_nxt = DRAIN;
            DRAIN:    if (dcnt == DCNT_W'(1)) state_nxt = host_sel ? OWN_HOST : OWN_CORE;
            default:  state_nxt = OWN_HOST;
        endcase
    end

    always_comb begin
        own_host  = (owner_q == HOST);
        own_cen   = own_host ? bus.host_cen : bus.core_cen;
        own_wen   = own_host ? bus.host_wen : bus.core_wen;
        oth_req   = own_host ? !bus.core_cen : !bus.host_cen;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = hold_addr;
        sram_d    = hold_d;
        drop_n    = 2'd0;
        push_vld  = 1'b0;
        if (reset) begin
            sram_addr = '0;
            sram_d    = '0;
        end else if (state == DRAIN) begin
            drop_n = 2'(!bus.host_cen) + 2'(!bus.core_cen);
        end else begin
            sram_cen  = own_cen;
            sram_wen  = own_wen;
            sram_addr = own_host ? bus.host_addr : bus.core_addr;
            sram_d    = own_host ? bus.host_d : bus.core_d;
            drop_n    = 2'(oth_req);
            push_vld  = !own_cen && own_wen;
        end
    end

    // Every DRAIN is preceded by an owned cycle, so the hold registers are
    // always loaded before they are driven onto the macro.
    always_ff @(posedge clk) begin
        if (state != DRAIN) begin
            hold_addr <= sram_addr;
            hold_d    <= sram_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= sat_add(drop_q, drop_n);
        end
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_tag (owner_q),
        .pop_vld  (pop_vld),
        .pop_tag  (pop_tag)
    );

    assign host_vld         = pop_vld && (pop_tag == HOST);
    assign core_vld         = pop_vld && (pop_tag == CORE);
    assign bus.host_q_valid = host_vld;
    assign bus.core_q_valid = core_vld;
    assign bus.host_q       = host_vld ? bus.sram_q : '0;
    assign bus.core_q       = core_vld ? bus.sram_q : '0;

    assign bus.sram_cen  = sram_cen;
    assign bus.sram_wen  = sram_wen;
    assign bus.sram_addr = sram_addr;
    assign bus.sram_d    = sram_d;

    assign owner       = owner_q;
    assign busy        = (state == DRAIN);
    assign switch_done = switch_done_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench: a 32x128 instance with 1-cycle reads and a 128x512 instance
// with 3-cycle reads, each backed by a small behavioural macro.
module tb_sram_access_ctrl;
    logic       clk = 1'b0;
    logic       rst_a, rst_b, hs_a, hs_b;
    logic       owner_a, busy_a, sd_a, owner_b, busy_b, sd_b;
    logic [7:0] dc_a, dc_b;
    int         checks = 0;
    int         errors = 0;

    sram_access_ctrl_if #(.DW(32),  .AW(7)) ifa ();
    sram_access_ctrl_if #(.DW(128), .AW(9)) ifb ();

    sram_access_ctrl #(.DW(32), .AW(7), .RD_LAT(1), .CW(8)) dut_a (
        .clk(clk), .reset(rst_a), .host_sel(hs_a), .owner(owner_a), .busy(busy_a),
        .switch_done(sd_a), .drop_cnt(dc_a), .bus(ifa.slave)
    );

    sram_access_ctrl #(.DW(128), .AW(9), .RD_LAT(3), .CW(8)) dut_b (
        .clk(clk), .reset(rst_b), .host_sel(hs_b), .owner(owner_b), .busy(busy_b),
        .switch_done(sd_b), .drop_cnt(dc_b), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem_a [0:127];
    logic [31:0]  rd_a;
    logic [127:0] mem_b [0:511];
    logic [127:0] q1_b, q2_b, q3_b;

    always @(posedge clk) begin
        if (!ifa.sram_cen) begin
            if (!ifa.sram_wen) mem_a[ifa.sram_addr] <= ifa.sram_d;
            else               rd_a <= mem_a[ifa.sram_addr];
        end
    end
    assign ifa.sram_q = rd_a;

    always @(posedge clk) begin
        if (!ifb.sram_cen) begin
            if (!ifb.sram_wen) mem_b[ifb.sram_addr] <= ifb.sram_d;
            else               q1_b <= mem_b[ifb.sram_addr];
        end
        q2_b <= q1_b;
        q3_b <= q2_b;
    end
    assign ifb.sram_q = q3_b;

    function automatic logic [127:0] pat_b(input int i);
        return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i),
                32'h3333_0000 + 32'(i), 32'h4444_0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.host_cen = 1'b1; ifa.host_wen = 1'b1; ifa.core_cen = 1'b1; ifa.core_wen = 1'b1;
    endtask

    task automatic idle_b();
        ifb.host_cen = 1'b1; ifb.host_wen = 1'b1; ifb.core_cen = 1'b1; ifb.core_wen = 1'b1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; hs_a = 1'b1; hs_b = 1'b1;
        idle_a(); idle_b();
        ifa.host_addr = '0; ifa.host_d = '0; ifa.core_addr = '0; ifa.core_d = '0;
        ifb.host_addr = '0; ifb.host_d = '0; ifb.core_addr = '0; ifb.core_d = '0;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checks++; if (owner_a !== 1'b1) begin errors++; $display("FAIL rst_owner: got %0b want 1", owner_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy_a); end
        checks++; if (sd_a !== 1'b0) begin errors++; $display("FAIL rst_switch_done: got %0b want 0", sd_a); end
        checks++; if (dc_a !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", dc_a); end
        checks++; if (ifa.host_q_valid !== 1'b0 || ifa.core_q_valid !== 1'b0) begin
            errors++; $display("FAIL rst_q_valid: got host %0b core %0b want 0 0", ifa.host_q_valid, ifa.core_q_valid); end
        checks++; if (ifa.host_q !== 32'd0 || ifa.core_q !== 32'd0) begin
            errors++; $display("FAIL rst_q: got host %h core %h want 0 0", ifa.host_q, ifa.core_q); end
        checks++; if (ifa.sram_cen !== 1'b1 || ifa.sram_wen !== 1'b1) begin
            errors++; $display("FAIL rst_sram_ctl: got cen %0b wen %0b want 1 1", ifa.sram_cen, ifa.sram_wen); end
        checks++; if (ifa.sram_addr !== 7'd0 || ifa.sram_d !== 32'd0) begin
            errors++; $display("FAIL rst_sram_bus: got addr %h d %h want 0 0", ifa.sram_addr, ifa.sram_d); end
        checks++; if (owner_b !== 1'b1 || busy_b !== 1'b0 || dc_b !== 8'd0) begin
            errors++; $display("FAIL rst_b: got owner %0b busy %0b drop %0d want 1 0 0", owner_b, busy_b, dc_b); end
        tick();
    endtask

    task automatic test_write_read();
        ifa.host_cen = 1'b0; ifa.host_wen = 1'b0; ifa.host_addr = 7'd5; ifa.host_d = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (ifa.sram_cen !== 1'b0 || ifa.sram_wen !== 1'b0 || ifa.sram_addr !== 7'd5 || ifa.sram_d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_pass: got cen %0b wen %0b addr %0d d %h want 0 0 5 deadbeef",
                               ifa.sram_cen, ifa.sram_wen, ifa.sram_addr, ifa.sram_d); end
        tick();
        ifa.host_wen = 1'b1; ifa.host_d = '0;
        @(negedge clk);
        checks++; if (ifa.host_q_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %0b want 0", ifa.host_q_valid); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (ifa.host_q_valid !== 1'b1 || ifa.host_q !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_host: got valid %0b q %h want 1 deadbeef", ifa.host_q_valid, ifa.host_q); end
        checks++; if (ifa.core_q_valid !== 1'b0 || ifa.core_q !== 32'd0) begin
            errors++; $display("FAIL rd_core_quiet: got valid %0b q %h want 0 0", ifa.core_q_valid, ifa.core_q); end
        tick();
        @(negedge clk);
        checks++; if (ifa.host_q_valid !== 1'b0) begin errors++; $display("FAIL rd_one_shot: got %0b want 0", ifa.host_q_valid); end
        tick();
    endtask

    task automatic test_switch();
        ifa.host_cen = 1'b0; ifa.host_wen = 1'b0; ifa.host_addr = 7'd9; ifa.host_d = 32'h12345678;
        tick();
        ifa.host_wen = 1'b1; ifa.host_d = '0; hs_a = 1'b0;
        @(negedge clk);
        checks++; if (ifa.sram_cen !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL sw_last_grant: got cen %0b busy %0b want 0 0", ifa.sram_cen, busy_a); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || owner_a !== 1'b1 || sd_a !== 1'b0) begin
            errors++; $display("FAIL sw_drain: got busy %0b owner %0b sd %0b want 1 1 0", busy_a, owner_a, sd_a); end
        checks++; if (ifa.host_q_valid !== 1'b1 || ifa.host_q !== 32'h12345678 || ifa.core_q_valid !== 1'b0) begin
            errors++; $display("FAIL sw_host_data: got hv %0b q %h cv %0b want 1 12345678 0",
                               ifa.host_q_valid, ifa.host_q, ifa.core_q_valid); end
        tick();
        ifa.core_cen = 1'b0; ifa.core_wen = 1'b1; ifa.core_addr = 7'd5;
        @(negedge clk);
        checks++; if (sd_a !== 1'b1 || owner_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL sw_done: got sd %0b owner %0b busy %0b want 1 0 0", sd_a, owner_a, busy_a); end
        checks++; if (ifa.sram_cen !== 1'b0 || ifa.sram_addr !== 7'd5) begin
            errors++; $display("FAIL sw_core_grant: got cen %0b addr %0d want 0 5", ifa.sram_cen, ifa.sram_addr); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (ifa.core_q_valid !== 1'b1 || ifa.core_q !== 32'hDEADBEEF || ifa.host_q_valid !== 1'b0) begin
            errors++; $display("FAIL sw_core_data: got cv %0b q %h hv %0b want 1 deadbeef 0",
                               ifa.core_q_valid, ifa.core_q, ifa.host_q_valid); end
        checks++; if (sd_a !== 1'b0) begin errors++; $display("FAIL sw_pulse_len: got %0b want 0", sd_a); end
        tick();
    endtask

    task automatic test_drop();
        hs_a = 1'b1;
        tick(); tick();
        ifa.core_cen = 1'b0; ifa.core_wen = 1'b1; ifa.core_addr = 7'd3; ifa.host_addr = 7'd2;
        @(negedge clk);
        checks++; if (owner_a !== 1'b1 || dc_a !== 8'd0) begin
            errors++; $display("FAIL drop_start: got owner %0b drop %0d want 1 0", owner_a, dc_a); end
        checks++; if (ifa.sram_cen !== 1'b1 || ifa.sram_addr !== 7'd2) begin
            errors++; $display("FAIL drop_no_access: got cen %0b addr %0d want 1 2", ifa.sram_cen, ifa.sram_addr); end
        tick();
        ifa.core_cen = 1'b1; hs_a = 1'b0;
        @(negedge clk);
        checks++; if (dc_a !== 8'd1) begin errors++; $display("FAIL drop_own: got %0d want 1", dc_a); end
        tick();
        ifa.host_cen = 1'b0; ifa.host_wen = 1'b0; ifa.host_addr = 7'd9; ifa.host_d = 32'hFFFFFFFF;
        ifa.core_cen = 1'b0; ifa.core_wen = 1'b0; hs_a = 1'b1;
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || ifa.sram_cen !== 1'b1 || ifa.sram_wen !== 1'b1 || ifa.sram_addr !== 7'd2) begin
            errors++; $display("FAIL drop_drain_bus: got busy %0b cen %0b wen %0b addr %0d want 1 1 1 2",
                               busy_a, ifa.sram_cen, ifa.sram_wen, ifa.sram_addr); end
        tick();
        idle_a();
        ifa.host_cen = 1'b0; ifa.host_wen = 1'b1; ifa.host_d = '0;
        @(negedge clk);
        checks++; if (dc_a !== 8'd3 || owner_a !== 1'b1 || sd_a !== 1'b0) begin
            errors++; $display("FAIL drop_total: got drop %0d owner %0b sd %0b want 3 1 0", dc_a, owner_a, sd_a); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (ifa.host_q_valid !== 1'b1 || ifa.host_q !== 32'h12345678) begin
            errors++; $display("FAIL drop_mem_intact: got valid %0b q %h want 1 12345678", ifa.host_q_valid, ifa.host_q); end
        tick();
    endtask

    task automatic test_toggle();
        hs_a = 1'b0;
        tick();
        hs_a = 1'b1;
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || owner_a !== 1'b1 || sd_a !== 1'b0) begin
            errors++; $display("FAIL tog_drain: got busy %0b owner %0b sd %0b want 1 1 0", busy_a, owner_a, sd_a); end
        tick();
        @(negedge clk);
        checks++; if (busy_a !== 1'b0 || owner_a !== 1'b1 || sd_a !== 1'b0) begin
            errors++; $display("FAIL tog_back: got busy %0b owner %0b sd %0b want 0 1 0", busy_a, owner_a, sd_a); end
        tick();
        @(negedge clk);
        checks++; if (sd_a !== 1'b0 || owner_a !== 1'b1) begin
            errors++; $display("FAIL tog_after: got sd %0b owner %0b want 0 1", sd_a, owner_a); end
        tick();
    endtask

    task automatic test_saturate();
        ifa.core_cen = 1'b0; ifa.core_wen = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        @(negedge clk);
        checks++; if (dc_a !== 8'd103) begin errors++; $display("FAIL sat_mid: got %0d want 103", dc_a); end
        for (int i = 0; i < 200; i++) tick();
        @(negedge clk);
        checks++; if (dc_a !== 8'd255) begin errors++; $display("FAIL sat_top: got %0d want 255", dc_a); end
        idle_a();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            ifb.host_cen = 1'b0; ifb.host_wen = 1'b0; ifb.host_addr = 9'(9'h100 + i); ifb.host_d = pat_b(i);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                ifb.host_cen = 1'b0; ifb.host_wen = 1'b1; ifb.host_addr = 9'(9'h100 + k); ifb.host_d = '0;
            end else begin
                idle_b();
            end
            @(negedge clk);
            if (k >= 3 && k < 7) begin
                checks++; if (ifb.host_q_valid !== 1'b1 || ifb.host_q !== pat_b(k - 3)) begin
                    errors++; $display("FAIL b2b_data[%0d]: got valid %0b q %h want 1 %h", k, ifb.host_q_valid, ifb.host_q, pat_b(k - 3)); end
            end else begin
                checks++; if (ifb.host_q_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle[%0d]: got valid %0b want 0", k, ifb.host_q_valid); end
            end
            checks++; if (ifb.core_q_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_core[%0d]: got %0b want 0", k, ifb.core_q_valid); end
            tick();
        end
    endtask

    task automatic test_switch_lat3();
        int busy_cycles;
        busy_cycles = 0;
        hs_b = 1'b0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (busy_b === 1'b1) busy_cycles++;
            checks++; if (owner_b !== 1'b1 || sd_b !== 1'b0) begin
                errors++; $display("FAIL l3_drain[%0d]: got owner %0b sd %0b want 1 0", k, owner_b, sd_b); end
            tick();
        end
        ifb.core_cen = 1'b0; ifb.core_wen = 1'b1; ifb.core_addr = 9'h101;
        @(negedge clk);
        if (busy_b === 1'b1) busy_cycles++;
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL l3_busy_len: got %0d want 3", busy_cycles); end
        checks++; if (sd_b !== 1'b1 || owner_b !== 1'b0) begin
            errors++; $display("FAIL l3_done: got sd %0b owner %0b want 1 0", sd_b, owner_b); end
        tick();
        idle_b();
        tick(); tick();
        @(negedge clk);
        checks++; if (ifb.core_q_valid !== 1'b1 || ifb.core_q !== pat_b(1)) begin
            errors++; $display("FAIL l3_core_data: got valid %0b q %h want 1 %h", ifb.core_q_valid, ifb.core_q, pat_b(1)); end
        tick();
        ifb.host_cen = 1'b0; ifb.host_wen = 1'b1;
        tick();
        idle_b();
        @(negedge clk);
        checks++; if (dc_b !== 8'd1) begin errors++; $display("FAIL l3_drop: got %0d want 1", dc_b); end
        tick();
    endtask

    task automatic test_reset_drain();
        ifb.core_cen = 1'b0; ifb.core_wen = 1'b1; ifb.core_addr = 9'h102; hs_b = 1'b1;
        @(negedge clk);
        checks++; if (ifb.sram_cen !== 1'b0) begin errors++; $display("FAIL rd_inflight_grant: got %0b want 0", ifb.sram_cen); end
        tick();
        idle_b(); rst_b = 1'b1;
        @(negedge clk);
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL rd_in_drain: got %0b want 1", busy_b); end
        tick();
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (owner_b !== 1'b1 || busy_b !== 1'b0 || dc_b !== 8'd0) begin
            errors++; $display("FAIL rdr_state: got owner %0b busy %0b drop %0d want 1 0 0", owner_b, busy_b, dc_b); end
        checks++; if (ifb.core_q_valid !== 1'b0 || ifb.host_q_valid !== 1'b0) begin
            errors++; $display("FAIL rdr_valid0: got core %0b host %0b want 0 0", ifb.core_q_valid, ifb.host_q_valid); end
        tick();
        @(negedge clk);
        checks++; if (ifb.core_q_valid !== 1'b0 || ifb.host_q_valid !== 1'b0 || ifb.core_q !== 128'd0) begin
            errors++; $display("FAIL rdr_flushed: got core %0b host %0b q %h want 0 0 0", ifb.core_q_valid, ifb.host_q_valid, ifb.core_q); end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_write_read();
        test_switch();
        test_drop();
        test_toggle();
        test_saturate();
        test_back_to_back();
        test_switch_lat3();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
